neo_frame_ctrl: RTL and testbench
=================================

# neo_frame_ctrl

Sequencer for the NEO datapath. On a `start` handshake it walks one frame of L samples through the sample memory read port: it issues read addresses, generates the datapath's window-shift strobe, and issues write-back strobes/addresses aligned to the datapath pipeline. It sits between the host/control logic and the NEO datapath plus its sample/result memories, and replaces free-running address counters with a framed start/busy/done transaction.

## Interface
Parameters:
- `M`, 16: memory depth, and the maximum frame length.
- `RD_LAT`, 1: memory read latency in cycles (1..3).
- `PIPE_LAT`, 2: cycles from the `shift_en` of sample k+1 to the write of result k (1..4).

Ports:
- `Clk`  in  1: clock; all logic is rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: frame request; sampled only in IDLE.
- `frame_len`  in  $clog2(M)+1: frame length L; latched on start acceptance.
- `abort`  in  1: synchronous frame cancel.
- `mem_re`  out  1: read enable.
- `raddr`  out  $clog2(M): read address.
- `shift_en`  out  1: datapath shifts in `rdata` this cycle.
- `mem_we`  out  1: result write enable.
- `waddr`  out  $clog2(M): result write address.
- `edge_zero`  out  1: datapath must drive `wdata` = 0 for this write.
- `busy`  out  1: frame in progress.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: one-cycle illegal-length pulse, coincident with `done`.

## Operation
- All outputs reset to 0. State resets to IDLE.
- States and transitions:
  - IDLE → RUN on `start` when L is legal (3 ≤ L ≤ M).
  - IDLE → DONE on `start` when L is illegal. This asserts `err`; no memory access is made.
  - RUN → DONE after the last write slot.
  - RUN → IDLE on `abort`.
  - DONE → IDLE unconditionally after 1 cycle.
- Read phase: `mem_re` = 1 and `raddr` = i for i = 0..L-1, one read per cycle with no gaps.
- `shift_en` is `mem_re` delayed by RD_LAT cycles. It is asserted exactly L times.
- Write slots: slot k (k = 0..L-1) falls exactly RD_LAT+PIPE_LAT+1 cycles after the read of sample k. In slot k, `waddr` = k.
- `mem_we` = 1 for k = 1..L-2, with `edge_zero` = 0. These are the NEO results centred on sample k.
- Slots k = 0 and k = L-1 (the edges) are governed by the Configuration macro.
- Pipeline bookkeeping uses a valid-bit delay line of depth RD_LAT+PIPE_LAT+1 plus a write counter. There is no second length compare on the write side.
- `start` while `busy`, or in the DONE cycle, is ignored. `frame_len` changes after acceptance have no effect.
- `abort` while in RUN:
  - Next cycle: IDLE, and all strobes are 0.
  - In-flight writes are dropped.
  - `done` and `err` are not pulsed.
- `abort` in IDLE or DONE is ignored. `abort` together with `start` in IDLE: `start` wins.
- Asserting `reset` mid-frame returns everything to reset values immediately. Nothing resumes.
- Address counters never wrap inside a frame, because L ≤ M.

## Timing
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled; cycle c is c edges later. Let D = RD_LAT+PIPE_LAT+2 (5 at defaults).
- `busy` = 1 in cycles 1..L+D-1.
- Read of sample i occurs in cycle 1+i. `shift_en` for sample i occurs in cycle 1+RD_LAT+i.
- Write slot k occurs in cycle k+D. At defaults: k=1 in cycle 6, last interior result in cycle L+3.
- `done` pulses in cycle L+D with `busy` = 0. This is independent of the macro.
- For an illegal L: `done` = `err` = 1 in cycle 1, and `busy` never rises.
- Minimum start-to-start interval is L+D+1 cycles (IDLE is re-entered in cycle L+D+1).

## Configuration
- `NEO_ZERO_EDGE_EN`
  - Defined: in slots 0 and L-1, `mem_we` = 1 and `edge_zero` = 1, so the result memory gets 0 at both ends of the frame.
  - Undefined: those slots have `mem_we` = 0, `edge_zero` is tied to 0, and the edge locations are untouched.
  - Timing and `done` cycle are identical in both builds.

## Test plan
- L=16, defaults, macro off:
  - `raddr` 0..15 in cycles 1..16.
  - `shift_en` in cycles 2..17.
  - `mem_we` with `waddr` 1..14 in cycles 6..19.
  - `done` in cycle 21; `busy` in cycles 1..20.
- L=16 with `NEO_ZERO_EDGE_EN`: additional writes with `edge_zero`=1 at `waddr` 0 (cycle 5) and `waddr` 15 (cycle 20). `done` is still in cycle 21.
- L=3, then L=2, then L=0:
  - L=3 yields a single write, `waddr`=1 in cycle 6, and `done` in cycle 8.
  - L=2 and L=0 each yield `done`=`err`=1 in cycle 1, with no `mem_re`.
- L=8, `abort` in cycle 4: IDLE from cycle 5 with all strobes 0 and no `done`. A following `start` with L=8 behaves exactly as a fresh frame.
- L=8:
  - `start` re-pulsed in cycles 3 and 13 (the DONE cycle) is ignored.
  - `start` in cycle 14 is accepted: reads restart at `raddr`=0 in cycle 15.
- L=16: `reset` asserted in cycle 9 makes all outputs 0 asynchronously. After release, the block is IDLE, and `start` with L=4 gives `done` in cycle 9.

Source files
------------

// File: rtl/neo_frame_ctrl.sv
// Frame sequencer for the NEO datapath: start/busy/done wrapper around read, shift and write-back strobes.
// Optional build macro NEO_ZERO_EDGE_EN: write zeros (edge_zero) into the first and last result slots.
module neo_frame_ctrl #(
  parameter int M        = 16,
  parameter int RD_LAT   = 1,
  parameter int PIPE_LAT = 2
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [$clog2(M):0]   frame_len,
  input  logic                 abort,
  output logic                 mem_re,
  output logic [$clog2(M)-1:0] raddr,
  output logic                 shift_en,
  output logic                 mem_we,
  output logic [$clog2(M)-1:0] waddr,
  output logic                 edge_zero,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int AW = $clog2(M);
  localparam int LW = AW + 1;
  localparam int N  = RD_LAT + PIPE_LAT + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [LW-1:0]   r_len;
  logic [N-2:0]    r_vld;
  logic [N-2:0]    r_lst;
  logic [AW-1:0]   r_wcnt;
  logic            r_slotVld;
  logic            r_slotLast;

  logic            w_lenOk;
  logic            w_rdLast;
  logic [N-1:0]    w_vldLine;
  logic [N-1:0]    w_lstLine;
  logic            w_slotIn;
  logic            w_slotLastIn;
  logic            w_interior;
  logic            w_we;
  logic            w_ez;

  assign w_lenOk      = (frame_len >= LW'(3)) && (frame_len <= LW'(M));
  assign w_rdLast     = mem_re && ({1'b0, raddr} == (r_len - LW'(1)));
  // Tap j of each line is the read strobe (or its last-sample tag) delayed j cycles.
  assign w_vldLine    = {r_vld, mem_re};
  assign w_lstLine    = {r_lst, w_rdLast};
  assign w_slotIn     = w_vldLine[N-1];
  assign w_slotLastIn = w_lstLine[N-1];
  assign w_interior   = (r_wcnt != '0) && !w_slotLastIn;

`ifdef NEO_ZERO_EDGE_EN
  assign w_we = w_slotIn;
  assign w_ez = w_slotIn && !w_interior;
`else
  assign w_we = w_slotIn && w_interior;
  assign w_ez = 1'b0;
`endif

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_vld      <= '0;
      r_lst      <= '0;
      r_wcnt     <= '0;
      r_slotVld  <= 1'b0;
      r_slotLast <= 1'b0;
      mem_re     <= 1'b0;
      raddr      <= '0;
      shift_en   <= 1'b0;
      mem_we     <= 1'b0;
      waddr      <= '0;
      edge_zero  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (start) begin
            r_len <= frame_len;
            if (w_lenOk) begin
              r_state <= RUN;
              busy    <= 1'b1;
              mem_re  <= 1'b1;
              raddr   <= '0;
              r_wcnt  <= '0;
            end else begin
              r_state <= DONE;
              done    <= 1'b1;
              err     <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_state    <= IDLE;
            busy       <= 1'b0;
            mem_re     <= 1'b0;
            raddr      <= '0;
            shift_en   <= 1'b0;
            mem_we     <= 1'b0;
            waddr      <= '0;
            edge_zero  <= 1'b0;
            r_vld      <= '0;
            r_lst      <= '0;
            r_wcnt     <= '0;
            r_slotVld  <= 1'b0;
            r_slotLast <= 1'b0;
          end else begin
            if (w_rdLast) begin
              mem_re <= 1'b0;
              raddr  <= '0;
            end else if (mem_re) begin
              raddr <= raddr + AW'(1);
            end
            r_vld      <= {r_vld[N-3:0], mem_re};
            r_lst      <= {r_lst[N-3:0], w_rdLast};
            shift_en   <= w_vldLine[RD_LAT-1];
            r_slotVld  <= w_slotIn;
            r_slotLast <= w_slotLastIn;
            mem_we     <= w_we;
            edge_zero  <= w_ez;
            waddr      <= w_slotIn ? r_wcnt : '0;
            if (w_slotIn) r_wcnt <= r_wcnt + AW'(1);
            // The pipeline has drained once the last slot has been presented.
            if (r_slotVld && r_slotLast) begin
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          err     <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neo_frame_ctrl.sv
// Scoreboard bench for neo_frame_ctrl: stimulus pushes expected strobes per cycle, a negedge monitor pops and compares.
// Edge-slot expectations follow NEO_ZERO_EDGE_EN when the bench is built with it.
module tb_neo_frame_ctrl;

  localparam int M        = 16;
  localparam int RD_LAT   = 1;
  localparam int PIPE_LAT = 2;
  localparam int D        = RD_LAT + PIPE_LAT + 2;
  localparam int AW       = $clog2(M);
  localparam int LW       = AW + 1;

  typedef struct {int cyc; int addr;}         rd_t;
  typedef struct {int cyc; int addr; int ez;} wr_t;
  typedef struct {int cyc; int err;}          dn_t;

  logic          Clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic          mem_re, shift_en, mem_we, edge_zero, busy, done, err;
  logic [AW-1:0] raddr, waddr;

  rd_t rdQ[$];
  wr_t wrQ[$];
  dn_t doneQ[$];
  int  shQ[$];
  int  busyQ[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prevBusy = 1'b0;
  int   c0;
  rd_t  mRd;
  wr_t  mWr;
  dn_t  mDn;
  int   mCyc;

  neo_frame_ctrl #(.M(M), .RD_LAT(RD_LAT), .PIPE_LAT(PIPE_LAT)) dut (
    .Clk(Clk), .reset(reset), .start(start), .frame_len(frame_len), .abort(abort),
    .mem_re(mem_re), .raddr(raddr), .shift_en(shift_en), .mem_we(mem_we),
    .waddr(waddr), .edge_zero(edge_zero), .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected strobe timeline of one frame, in absolute bench cycles; abortRel>0 truncates it.
  task automatic pushExpect(input int s0, input int len, input int abortRel);
    int  lim;
    rd_t r;
    wr_t w;
    dn_t d;
    if (len < 3 || len > M) begin
      d.cyc = s0 + 1; d.err = 1;
      doneQ.push_back(d);
      return;
    end
    lim = (abortRel > 0) ? s0 + abortRel : s0 + len + D + 100;
    busyQ.push_back(s0 + 1);
    busyQ.push_back((abortRel > 0) ? s0 + abortRel + 1 : s0 + len + D);
    for (int i = 0; i < len; i++) begin
      if (s0 + 1 + i <= lim) begin
        r.cyc = s0 + 1 + i; r.addr = i;
        rdQ.push_back(r);
      end
      if (s0 + 1 + RD_LAT + i <= lim) shQ.push_back(s0 + 1 + RD_LAT + i);
    end
    for (int k = 0; k < len; k++) begin
      w.cyc = s0 + k + D; w.addr = k; w.ez = 0;
      if (w.cyc <= lim) begin
        if (k > 0 && k < len - 1) begin
          wrQ.push_back(w);
        end else begin
`ifdef NEO_ZERO_EDGE_EN
          w.ez = 1;
          wrQ.push_back(w);
`endif
        end
      end
    end
    if (abortRel == 0) begin
      d.cyc = s0 + len + D; d.err = 0;
      doneQ.push_back(d);
    end
  endtask

  task automatic applyStimulus(input int len, input int abortRel, output int s0);
    @(negedge Clk);
    start     = 1'b1;
    frame_len = LW'(len);
    s0        = cyc;
    pushExpect(s0, len, abortRel);
    @(negedge Clk);
    start     = 1'b0;
    frame_len = '1;
    if (abortRel > 0) begin
      while (cyc < s0 + abortRel) @(negedge Clk);
      abort = 1'b1;
      @(negedge Clk);
      abort = 1'b0;
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_mem_re"},    int'(mem_re),    0);
    checkOutput({tag, "_raddr"},     int'(raddr),     0);
    checkOutput({tag, "_shift_en"},  int'(shift_en),  0);
    checkOutput({tag, "_mem_we"},    int'(mem_we),    0);
    checkOutput({tag, "_waddr"},     int'(waddr),     0);
    checkOutput({tag, "_edge_zero"}, int'(edge_zero), 0);
    checkOutput({tag, "_busy"},      int'(busy),      0);
    checkOutput({tag, "_done"},      int'(done),      0);
    checkOutput({tag, "_err"},       int'(err),       0);
  endtask

  task automatic checkQueuesEmpty(input string tag);
    checkOutput({tag, "_rd_left"},    rdQ.size(),   0);
    checkOutput({tag, "_shift_left"}, shQ.size(),   0);
    checkOutput({tag, "_wr_left"},    wrQ.size(),   0);
    checkOutput({tag, "_done_left"},  doneQ.size(), 0);
    checkOutput({tag, "_busy_left"},  busyQ.size(), 0);
  endtask

  task automatic flushQueues();
    rdQ.delete(); shQ.delete(); wrQ.delete(); doneQ.delete(); busyQ.delete();
  endtask

  // Monitor: every strobe the DUT raises must match the head of its queue.
  always @(negedge Clk) begin
    if (!reset) begin
      if (mem_re) begin
        checkOutput("rd_expected", int'(rdQ.size() > 0), 1);
        if (rdQ.size() > 0) begin
          mRd = rdQ.pop_front();
          checkOutput("rd_cycle", cyc, mRd.cyc);
          checkOutput("raddr", int'(raddr), mRd.addr);
          checkOutput("rd_busy", int'(busy), 1);
        end
      end
      if (shift_en) begin
        checkOutput("shift_expected", int'(shQ.size() > 0), 1);
        if (shQ.size() > 0) begin
          mCyc = shQ.pop_front();
          checkOutput("shift_cycle", cyc, mCyc);
        end
      end
      if (mem_we) begin
        checkOutput("wr_expected", int'(wrQ.size() > 0), 1);
        if (wrQ.size() > 0) begin
          mWr = wrQ.pop_front();
          checkOutput("wr_cycle", cyc, mWr.cyc);
          checkOutput("waddr", int'(waddr), mWr.addr);
          checkOutput("edge_zero", int'(edge_zero), mWr.ez);
        end
      end else if (edge_zero) begin
        checkOutput("edge_zero_without_we", int'(edge_zero), 0);
      end
      if (done) begin
        checkOutput("done_expected", int'(doneQ.size() > 0), 1);
        if (doneQ.size() > 0) begin
          mDn = doneQ.pop_front();
          checkOutput("done_cycle", cyc, mDn.cyc);
          checkOutput("err", int'(err), mDn.err);
          checkOutput("done_busy", int'(busy), 0);
        end
      end else if (err) begin
        checkOutput("err_without_done", int'(err), 0);
      end
      if (busy != prevBusy) begin
        checkOutput("busy_edge_expected", int'(busyQ.size() > 0), 1);
        if (busyQ.size() > 0) begin
          mCyc = busyQ.pop_front();
          checkOutput("busy_edge_cycle", cyc, mCyc);
        end
      end
    end
    prevBusy = busy;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #3;
    checkIdleOutputs("reset");
    repeat (2) @(negedge Clk);
    #2 reset = 1'b0;

    applyStimulus(16, 0, c0);
    repeat (16 + D + 3) @(negedge Clk);
    checkQueuesEmpty("L16");

    applyStimulus(3, 0, c0);
    repeat (3 + D + 3) @(negedge Clk);
    checkQueuesEmpty("L3");

    applyStimulus(2, 0, c0);
    repeat (4) @(negedge Clk);
    applyStimulus(0, 0, c0);
    repeat (4) @(negedge Clk);
    applyStimulus(17, 0, c0);
    repeat (4) @(negedge Clk);
    checkQueuesEmpty("illegal");

    applyStimulus(8, 4, c0);
    repeat (D + 4) @(negedge Clk);
    checkIdleOutputs("abort");
    checkQueuesEmpty("abort");
    applyStimulus(8, 0, c0);
    repeat (8 + D + 3) @(negedge Clk);
    checkQueuesEmpty("after_abort");

    // Start re-pulsed mid-frame and in the DONE cycle, then accepted one cycle later.
    applyStimulus(8, 0, c0);
    while (cyc < c0 + 3) @(negedge Clk);
    start = 1'b1; frame_len = LW'(8);
    @(negedge Clk);
    start = 1'b0;
    while (cyc < c0 + 13) @(negedge Clk);
    start = 1'b1; frame_len = LW'(8);
    @(negedge Clk);
    pushExpect(c0 + 14, 8, 0);
    @(negedge Clk);
    start = 1'b0;
    repeat (8 + D + 3) @(negedge Clk);
    checkQueuesEmpty("restart");

    applyStimulus(16, 0, c0);
    while (cyc < c0 + 9) @(negedge Clk);
    #2 reset = 1'b1;
    #1 checkIdleOutputs("midreset");
    flushQueues();
    @(negedge Clk);
    #2 reset = 1'b0;
    applyStimulus(4, 0, c0);
    repeat (4 + D + 3) @(negedge Clk);
    checkQueuesEmpty("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
